// File: rtl/spart_pkg.sv
// Shared definitions for the SPART serial port: bus register map, transmitter
// state encoding and the reset-time baud divisor.
package spart_pkg;

  localparam logic [1:0] ADDR_TX   = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // 4800 baud from the reference system clock.
  localparam logic [15:0] DEFAULT_DIV = 16'h0412;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Baud-rate counter shared by the SPART transmitter and receiver: one bit_tick
// every max(divisor,1) clocks, re-armed to a full period by restart.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor,
  input  logic        restart,
  output logic        bit_tick
);

  logic [15:0] cnt;
  logic [15:0] reload;

  // A zero divisor behaves as one, giving a tick on every clock.
  assign reload   = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
  assign bit_tick = (cnt == 16'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= 16'd0;
    end else if (restart || bit_tick) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: bus-programmable divisor, one-byte holding register and
// an 8N1 frame shifter with a registered serial output.
module spart_tx #(
  parameter logic [15:0] DEFAULT_DIV = spart_pkg::DEFAULT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] wr_data,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy
);

  import spart_pkg::*;

  tx_state_t   state;
  logic        iocs_q;
  logic        armed;
  logic        wr_accept;
  logic        wr_tx;
  logic [15:0] divisor;
  logic [7:0]  hold;
  logic        hold_full;
  logic [7:0]  shifter;
  logic [2:0]  bit_cnt;
  logic        bit_tick;
  logic        load_shifter;
  logic        txd_next;

  // armed stays low after reset until iocs has been seen low, so a chip
  // select already asserted at release never counts as a fresh access.
  assign wr_accept = iocs && !iocs_q && armed && !iorw;
  assign wr_tx     = wr_accept && (ioaddr == ADDR_TX) && !hold_full;

  assign load_shifter = hold_full && ((state == IDLE) || ((state == STOP) && bit_tick));

  assign tbr     = !hold_full;
  assign tx_busy = (state != IDLE);

  // NOTE: every register, including the data registers, gets a defined reset
  // value so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iocs_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      iocs_q <= iocs;
      if (!iocs) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= DEFAULT_DIV;
    end else if (wr_accept) begin
      case (ioaddr)
        ADDR_DBL:  divisor[7:0]  <= wr_data;
        ADDR_DBH:  divisor[15:8] <= wr_data;
        ADDR_STAT: ;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold      <= 8'd0;
      hold_full <= 1'b0;
    end else if (load_shifter) begin
      hold_full <= 1'b0;
    end else if (wr_tx) begin
      hold      <= wr_data;
      hold_full <= 1'b1;
    end
  end

  spart_baud_gen u_baud (
    .clk      (clk),
    .rst      (rst),
    .divisor  (divisor),
    .restart  (load_shifter),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shifter <= 8'd0;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            shifter <= hold;
            state   <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            shifter <= {1'b0, shifter[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          // Chaining straight into START keeps back-to-back frames gapless.
          if (bit_tick) begin
            if (hold_full) begin
              shifter <= hold;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    txd_next = 1'b1;
    case (state)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shifter[0];
      default: txd_next = 1'b1;
    endcase
  end

  // The serial line lags the state by one clock; reset forces it high at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd <= 1'b1;
    end else begin
      txd <= txd_next;
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: directed scenarios plus randomized frames
// compared against a waveform model built from the 8N1 framing rules.
module tb_spart_tx;
  import spart_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] wr_data;
  logic       txd;
  logic       tbr;
  logic       tx_busy;

  always #5 clk = ~clk;

  spart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .iocs    (iocs),
    .iorw    (iorw),
    .ioaddr  (ioaddr),
    .wr_data (wr_data),
    .txd     (txd),
    .tbr     (tbr),
    .tx_busy (tx_busy)
  );

  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  logic log_txd[$];
  logic log_tbr[$];
  logic log_busy[$];
  logic exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // One clock: log outputs at the falling edge, indexed by posedge count.
  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    log_txd.push_back(txd);
    log_tbr.push_back(tbr);
    log_busy.push_back(tx_busy);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input int hold_clks,
                           output int acc);
    iocs    = 1'b1;
    iorw    = 1'b0;
    ioaddr  = a;
    wr_data = d;
    acc     = cyc + 1;
    repeat (hold_clks) step();
    iocs = 1'b0;
    step();
  endtask

  // Reference waveform: start bit, 8 data bits LSB first, stop bit, each
  // lasting max(div,1) clocks.
  task automatic model_frame(input logic [7:0] b, input int div);
    int p;
    p = (div == 0) ? 1 : div;
    repeat (p) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (p) exp_q.push_back(b[i]);
    repeat (p) exp_q.push_back(1'b1);
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic compare_window(input string tag, input int start);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= log_txd.size()) bad++;
      else if (log_txd[start + i] !== exp_q[i]) bad++;
    end
    check(tag, bad, 0);
    exp_q.delete();
  endtask

  function automatic int first_zero_after(input int a);
    for (int i = a + 1; i < log_txd.size() && i < a + 200; i++)
      if (log_txd[i] === 1'b0) return i;
    return -1000;
  endfunction

  initial begin
    int acc, acc2, acc3, base, bad_txd, bad_tbr, bad_busy, zeros, div;
    logic [7:0] b1, b2;

    log_txd.push_back(1'b1);
    log_tbr.push_back(1'b1);
    log_busy.push_back(1'b0);

    // Reset with chip select already asserted on a TX write.
    rst = 1'b0; iocs = 1'b1; iorw = 1'b0; ioaddr = ADDR_TX; wr_data = 8'h5A;
    run(3);
    check("rst_txd", txd, 1);
    check("rst_tbr", tbr, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_div", dut.divisor, 16'h0412);
    rst  = 1'b1;
    base = cyc;
    run(2000);
    bad_txd = 0; bad_tbr = 0; bad_busy = 0;
    for (int i = base + 1; i <= cyc; i++) begin
      if (log_txd[i] !== 1'b1) bad_txd++;
      if (log_tbr[i] !== 1'b1) bad_tbr++;
      if (log_busy[i] !== 1'b0) bad_busy++;
    end
    check("idle_txd_glitches", bad_txd, 0);
    check("idle_tbr_glitches", bad_tbr, 0);
    check("idle_busy_glitches", bad_busy, 0);
    check("idle_div", dut.divisor, 16'h0412);
    iocs = 1'b0;
    step();

    // A read access must not load anything.
    iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_TX; wr_data = 8'h11;
    run(2);
    iocs = 1'b0; iorw = 1'b0;
    run(5);
    check("read_tbr", tbr, 1);
    check("read_busy", tx_busy, 0);

    // Divisor 4, frame 0x6D.
    bus_write(ADDR_DBL, 8'h04, 2, acc);
    bus_write(ADDR_DBH, 8'h00, 2, acc);
    check("cfg_div4", dut.divisor, 16'h0004);
    bus_write(ADDR_TX, 8'h6D, 1, acc);
    run(60);
    check("6d_tbr_after_accept", log_tbr[acc], 0);
    check("6d_txd_before_start", log_txd[acc + 1], 1);
    check("6d_start_latency", first_zero_after(acc) - acc, 2);
    check("6d_busy_in_frame", log_busy[acc + 1], 1);
    model_frame(8'h6D, 4);
    model_idle(10);
    compare_window("6d_waveform", acc + 2);
    check("6d_busy_end", tx_busy, 0);

    // iocs held 15 clocks: exactly one frame.
    bus_write(ADDR_TX, 8'hA5, 15, acc);
    run(70);
    model_frame(8'hA5, 4);
    model_idle(40);
    compare_window("a5_single_frame", acc + 2);

    // Back-to-back 0x55, 0xAA; third write dropped while tbr=0.
    bus_write(ADDR_TX, 8'h55, 1, acc);
    run(3);
    bus_write(ADDR_TX, 8'hAA, 1, acc2);
    bus_write(ADDR_TX, 8'h33, 1, acc3);
    run(100);
    check("b2b_tbr_first_accept", log_tbr[acc], 0);
    check("b2b_tbr_first_moved", log_tbr[acc + 1], 1);
    check("b2b_tbr_second_accept", log_tbr[acc2], 0);
    check("b2b_tbr_held", log_tbr[acc + 40], 0);
    check("b2b_tbr_second_moved", log_tbr[acc + 41], 1);
    check("b2b_busy_last", log_busy[acc + 80], 1);
    check("b2b_busy_done", log_busy[acc + 81], 0);
    model_frame(8'h55, 4);
    model_frame(8'hAA, 4);
    model_idle(20);
    compare_window("b2b_waveform", acc + 2);

    // Divisor 0 behaves as 1.
    bus_write(ADDR_DBL, 8'h00, 2, acc);
    check("cfg_div0", dut.divisor, 16'h0000);
    b1 = 8'($urandom_range(0, 255));
    bus_write(ADDR_TX, b1, 1, acc);
    run(20);
    check("div0_start_latency", first_zero_after(acc) - acc, 2);
    model_frame(b1, 0);
    model_idle(5);
    compare_window("div0_waveform", acc + 2);

    // Randomized divisors and byte pairs sent back to back.
    for (int n = 0; n < 5; n++) begin
      div = int'($urandom_range(1, 6));
      b1  = 8'($urandom_range(0, 255));
      b2  = 8'($urandom_range(0, 255));
      bus_write(ADDR_DBL, 8'(div), 1, acc);
      bus_write(ADDR_TX, b1, 1, acc);
      run(2);
      bus_write(ADDR_TX, b2, 1, acc2);
      run(20 * div + 10);
      model_frame(b1, div);
      model_frame(b2, div);
      model_idle(5);
      compare_window($sformatf("rand%0d_div%0d_%02h_%02h", n, div, b1, b2), acc + 2);
    end

    // Reset during data bit 3 (a zero bit of 0x96).
    bus_write(ADDR_DBL, 8'h04, 1, acc);
    bus_write(ADDR_TX, 8'h96, 1, acc);
    run(acc + 19 - cyc);
    check("abort_bit3_low", log_txd[acc + 19], 0);
    rst = 1'b0;
    #1;
    check("abort_txd_async", txd, 1);
    check("abort_busy", tx_busy, 0);
    check("abort_tbr", tbr, 1);
    run(3);
    rst = 1'b1;
    run(2);
    check("post_rst_div", dut.divisor, 16'h0412);
    check("post_rst_busy", tx_busy, 0);
    check("post_rst_txd", txd, 1);

    // Default divisor: start bit lasts 1042 clocks.
    bus_write(ADDR_TX, 8'hFF, 1, acc);
    run(1050);
    check("dflt_start_latency", first_zero_after(acc) - acc, 2);
    zeros = 0;
    for (int i = acc + 2; i < log_txd.size() && log_txd[i] === 1'b0; i++) zeros++;
    check("dflt_start_len", zeros, 1042);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
